// File: rtl/i2c_pkg.sv
// Shared types and command-word layout for the I2C command dispatcher.
package i2c_pkg;

   typedef enum logic [1:0] {
      D_IDLE   = 2'd0,
      D_LAUNCH = 2'd1,
      D_WAIT   = 2'd2
   } disp_state_t;

   localparam int   CMD_W        = 16;
   localparam int   CMD_DATA_LSB = 0;
   localparam int   CMD_ADDR_LSB = 8;
   localparam int   CMD_RW_BIT   = 15;
   localparam logic RW_READ      = 1'b1;

   function automatic logic [CMD_W-1:0] pack_cmd(input logic       rw,
                                                  input logic [6:0] addr,
                                                  input logic [7:0] data);
      return {rw, addr, data};
   endfunction

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy and a sticky overflow flag.
module i2c_cmd_fifo
   import i2c_pkg::*;
#(
   parameter  int DEPTH = 8,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             i2c_clock_in,
   input  logic             i2c_reset_n_in,
   input  logic             wr_en,
   input  logic [CMD_W-1:0] wr_data,
   input  logic             rd_en,
   output logic [CMD_W-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [PTR_W:0]   level,
   output logic             overflow
);

   localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

   logic [CMD_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             push;
   logic             pop;

   assign push    = wr_en && !full;
   assign pop     = rd_en && !empty;
   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign level   = count;
   assign rd_data = mem[rd_ptr];

   // Storage is not reset; a reset only discards entries by clearing the pointers.
   always_ff @(posedge i2c_clock_in) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge i2c_clock_in or negedge i2c_reset_n_in) begin
      if (!i2c_reset_n_in) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (wr_en && full) overflow <= 1'b1;
      end
   end

endmodule

// File: rtl/i2c_cmd_dispatcher.sv
// Queues host I2C commands and issues them one at a time to the I2C master FSM.
//   state    | meaning
//   D_IDLE   | waiting for a queued command while the FSM reports ready
//   D_LAUNCH | enable high, waiting for the FSM to drop ready
//   D_WAIT   | transaction in flight, waiting for ready to return
module i2c_cmd_dispatcher
   import i2c_pkg::*;
#(
   parameter  int DEPTH = 8,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             i2c_clock_in,
   input  logic             i2c_reset_n_in,
   input  logic             cmd_wr_en,
   input  logic             cmd_rw_in,
   input  logic [6:0]       cmd_addr_in,
   input  logic [7:0]       cmd_data_in,
   output logic             cmd_full,
   output logic             cmd_empty,
   output logic [PTR_W:0]   cmd_level,
   output logic             cmd_overflow,
   output logic             busy,
   output logic             enable,
   output logic             rw_bit,
   output logic [6:0]       fifo_to_fsm_addr_in,
   output logic [7:0]       fifo_to_fsm_data_in,
   input  logic             ready,
   input  logic [7:0]       i2c_master_data_out,
   output logic [7:0]       rd_data_out,
   output logic             rd_valid,
   input  logic             rd_ack,
   output logic             rd_overrun
);

   disp_state_t      state;
   disp_state_t      state_nxt;
   logic             launch;
   logic             capture;
   logic [CMD_W-1:0] head;

   i2c_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .i2c_clock_in   (i2c_clock_in),
      .i2c_reset_n_in (i2c_reset_n_in),
      .wr_en          (cmd_wr_en),
      .wr_data        (pack_cmd(cmd_rw_in, cmd_addr_in, cmd_data_in)),
      .rd_en          (launch),
      .rd_data        (head),
      .full           (cmd_full),
      .empty          (cmd_empty),
      .level          (cmd_level),
      .overflow       (cmd_overflow)
   );

   always_ff @(posedge i2c_clock_in or negedge i2c_reset_n_in) begin
      if (!i2c_reset_n_in) state <= D_IDLE;
      else                 state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      launch    = 1'b0;
      capture   = 1'b0;
      case (state)
         D_IDLE: begin
            if (!cmd_empty && ready) begin
               launch    = 1'b1;
               state_nxt = D_LAUNCH;
            end
         end
         D_LAUNCH: begin
            if (!ready) state_nxt = D_WAIT;
         end
         D_WAIT: begin
            if (ready) begin
               capture   = (rw_bit == RW_READ);
               state_nxt = D_IDLE;
            end
         end
         default: state_nxt = D_IDLE;
      endcase
   end

   // enable is a decode of the state register, so an async reset drops it at once.
   assign enable = (state == D_LAUNCH);
   assign busy   = (state != D_IDLE);

   always_ff @(posedge i2c_clock_in or negedge i2c_reset_n_in) begin
      if (!i2c_reset_n_in) begin
         rw_bit              <= 1'b0;
         fifo_to_fsm_addr_in <= '0;
         fifo_to_fsm_data_in <= '0;
         rd_data_out         <= '0;
         rd_valid            <= 1'b0;
         rd_overrun          <= 1'b0;
      end else begin
         if (launch) begin
            rw_bit              <= head[CMD_RW_BIT];
            fifo_to_fsm_addr_in <= head[CMD_ADDR_LSB +: 7];
            fifo_to_fsm_data_in <= head[CMD_DATA_LSB +: 8];
         end
         // A capture beats a same-cycle acknowledge; that case is not an overrun.
         if (capture) begin
            rd_data_out <= i2c_master_data_out;
            rd_valid    <= 1'b1;
            if (rd_valid && !rd_ack) rd_overrun <= 1'b1;
         end else if (rd_ack) begin
            rd_valid <= 1'b0;
         end
      end
   end

endmodule
